// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_pkg
// Brief    : Shared types and AHB constants for the interrupt-controller
//            AHB-lite slave interface.
// Revision : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

  // Bus-interface state machine encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } state_t;

  // HTRANS encodings
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  // HSIZE encodings supported by the register block
  localparam logic [2:0] c_hsize_byte = 3'd0;
  localparam logic [2:0] c_hsize_half = 3'd1;
  localparam logic [2:0] c_hsize_word = 3'd2;

  // HRESP codes
  localparam logic c_hresp_okay  = 1'b0;
  localparam logic c_hresp_error = 1'b1;

endpackage : int_ctrl_pkg
`default_nettype wire

// File: rtl/int_ctrl_strb_dec.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_strb_dec
// Brief    : Combinational byte-lane decode and illegal-transfer detection
//            from HSIZE and the low address bits.
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl_strb_dec
  import int_ctrl_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strobe,
  output logic       o_illegal
);

  // Lane select per size; misaligned or oversized transfers flagged illegal
  always_comb begin
    o_strobe  = 4'b0000;
    o_illegal = 1'b0;
    case (i_size)
      c_hsize_byte: o_strobe = 4'b0001 << i_addr_lo;
      c_hsize_half: begin
        o_strobe  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_illegal = i_addr_lo[0];
      end
      c_hsize_word: begin
        o_strobe  = 4'b1111;
        o_illegal = |i_addr_lo;
      end
      default:      o_illegal = 1'b1;
    endcase
  end

endmodule : int_ctrl_strb_dec
`default_nettype wire

// File: rtl/int_ctrl_ahb_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_ahb_if
// Brief    : AHB-lite slave front end for the interrupt-controller register
//            block. Zero-wait writes, one-wait reads, two-cycle ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl_ahb_if
  import int_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 12
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hsels,
  input  logic [ADDRWIDTH-1:0] haddrs,
  input  logic [1:0]           htranss,
  input  logic [2:0]           hsizes,
  input  logic                 hwrites,
  input  logic                 hreadys,
  input  logic [31:0]          hwdatas,
  output logic                 hreadyouts,
  output logic                 hresps,
  output logic [31:0]          hrdatas,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 read_en,
  output logic                 write_en,
  output logic [3:0]           byte_strobe,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata
);

  state_t                 r_state;
  logic                   r_hreadyout;
  logic                   r_hresp;
  logic [31:0]            r_hrdata;
  logic [ADDRWIDTH-1:0]   r_addr;
  logic                   r_read_en;
  logic                   r_write_en;
  logic [3:0]             r_byte_strobe;

  logic                   w_accept;
  logic [3:0]             w_strobe;
  logic                   w_illegal;
  logic                   w_unused;

  // Only NONSEQ/SEQ matter; bit 0 distinguishes them and is not needed
  assign w_unused = htranss[0];
  assign w_accept = hsels & hreadys & htranss[1];

  int_ctrl_strb_dec u_strb_dec (
    .i_size    (hsizes),
    .i_addr_lo (haddrs[1:0]),
    .o_strobe  (w_strobe),
    .o_illegal (w_illegal)
  );

  // Transfer FSM; every bus and strobe output is registered here
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state       <= ST_IDLE;
      r_hreadyout   <= 1'b1;
      r_hresp       <= c_hresp_okay;
      r_hrdata      <= 32'h0;
      r_addr        <= '0;
      r_read_en     <= 1'b0;
      r_write_en    <= 1'b0;
      r_byte_strobe <= 4'b0000;
    end else begin
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      case (r_state)
        ST_RD_WAIT: begin
          // Register-block data is captured while read_en is high
          r_hrdata    <= rdata;
          r_state     <= ST_RD_DATA;
          r_hreadyout <= 1'b1;
          r_hresp     <= c_hresp_okay;
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= c_hresp_error;
        end
        default: begin
          // IDLE, WR, RD_DATA and ERR2 can all take a new address phase
          if (w_accept && w_illegal) begin
            r_state     <= ST_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= c_hresp_error;
          end else if (w_accept) begin
            r_addr        <= haddrs;
            r_byte_strobe <= w_strobe;
            r_hresp       <= c_hresp_okay;
            if (hwrites) begin
              r_state     <= ST_WR;
              r_write_en  <= 1'b1;
              r_hreadyout <= 1'b1;
            end else begin
              r_state     <= ST_RD_WAIT;
              r_read_en   <= 1'b1;
              r_hreadyout <= 1'b0;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= c_hresp_okay;
          end
        end
      endcase
    end
  end

  assign hreadyouts  = r_hreadyout;
  assign hresps      = r_hresp;
  assign hrdatas     = r_hrdata;
  assign addr        = r_addr;
  assign read_en     = r_read_en;
  assign write_en    = r_write_en;
  assign byte_strobe = r_byte_strobe;
  assign wdata       = hwdatas;

endmodule : int_ctrl_ahb_if
`default_nettype wire

// File: tb/tb_int_ctrl_ahb_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl_ahb_if
// Brief    : Directed self-checking bench for int_ctrl_ahb_if with a small
//            register-block model and write/read scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_ctrl_ahb_if;

  logic        hclk;
  logic        hresetn;
  logic        hsels;
  logic [11:0] haddrs;
  logic [1:0]  htranss;
  logic [2:0]  hsizes;
  logic        hwrites;
  wire logic   hreadys;
  logic [31:0] hwdatas;
  logic        hreadyouts;
  logic        hresps;
  logic [31:0] hrdatas;
  logic [11:0] addr;
  logic        read_en;
  logic        write_en;
  logic [3:0]  byte_strobe;
  logic [31:0] wdata;
  logic [31:0] rdata;

  typedef struct {
    logic [11:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem [0:1023];

  // Single slave on the bus: its ready is the bus-wide ready
  assign hreadys = hreadyouts;
  assign rdata   = mem[addr[11:2]];

  int_ctrl_ahb_if #(.ADDRWIDTH(12)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsels       (hsels),
    .haddrs      (haddrs),
    .htranss     (htranss),
    .hsizes      (hsizes),
    .hwrites     (hwrites),
    .hreadys     (hreadys),
    .hwdatas     (hwdatas),
    .hreadyouts  (hreadyouts),
    .hresps      (hresps),
    .hrdatas     (hrdatas),
    .addr        (addr),
    .read_en     (read_en),
    .write_en    (write_en),
    .byte_strobe (byte_strobe),
    .wdata       (wdata),
    .rdata       (rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Register-block model: byte-lane writes
  always @(posedge hclk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++)
        if (byte_strobe[b]) mem[addr[11:2]][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every write strobe must match the next expected write
  always @(negedge hclk) begin
    if (write_en) begin
      if (wr_q.size() == 0) begin
        check("spurious_write_en", 32'(write_en), 32'h0);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check("wr_addr",   32'(addr),        32'(e.a));
        check("wr_strobe", 32'(byte_strobe), 32'(e.s));
        check("wr_data",   wdata,            e.d);
      end
    end
    if (read_en && write_en) check("strobe_exclusive", 32'h1, 32'h0);
  end

  // Drive one address phase and return #1 after the edge that accepts it
  task automatic addr_phase(input logic [11:0] a, input logic [2:0] sz, input logic wr);
    logic rdy;
    hsels   = 1'b1;
    haddrs  = a;
    hsizes  = sz;
    hwrites = wr;
    htranss = 2'b10;
    for (int i = 0; i < 8; i++) begin
      rdy = hreadys;
      @(posedge hclk); #1;
      if (rdy) return;
    end
    check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic go_idle();
    htranss = 2'b00;
    hsels   = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic [3:0] s);
    wr_q.push_back('{a: a, s: s, d: d});
    addr_phase(a, sz, 1'b1);
    go_idle();
    hwdatas = d;
    check("wr_write_en",  32'(write_en),   32'h1);
    check("wr_hreadyout", 32'(hreadyouts), 32'h1);
    check("wr_hresp",     32'(hresps),     32'h0);
    @(posedge hclk); #1;
    check("wr_done_write_en", 32'(write_en), 32'h0);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    addr_phase(a, 3'd2, 1'b0);
    go_idle();
    check("rdw_read_en",   32'(read_en),    32'h1);
    check("rdw_hreadyout", 32'(hreadyouts), 32'h0);
    check("rdw_addr",      32'(addr),       32'(a));
    @(posedge hclk); #1;
    check("rdd_read_en",   32'(read_en),    32'h0);
    check("rdd_hreadyout", 32'(hreadyouts), 32'h1);
    check("rdd_hresp",     32'(hresps),     32'h0);
    check("rdd_hrdata",    hrdatas,         rd_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hreadyout"}, 32'(hreadyouts),  32'h1);
    check({tag, "_hresp"},     32'(hresps),      32'h0);
    check({tag, "_hrdata"},    hrdatas,          32'h0);
    check({tag, "_read_en"},   32'(read_en),     32'h0);
    check({tag, "_write_en"},  32'(write_en),    32'h0);
    check({tag, "_addr"},      32'(addr),        32'h0);
    check({tag, "_strobe"},    32'(byte_strobe), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[12'hFE0 >> 2] = 32'h0000_0017;
    hresetn = 1'b0;
    hsels   = 1'b0;
    haddrs  = 12'h0;
    htranss = 2'b00;
    hsizes  = 3'd0;
    hwrites = 1'b0;
    hwdatas = 32'h0;

    // Reset state
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_reset_outputs("reset");
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Word, byte and halfword writes
    do_write(12'h004, 3'd2, 32'hA5A5_1234, 4'b1111);
    do_write(12'h002, 3'd0, 32'h00CC_0000, 4'b0100);
    do_write(12'h002, 3'd1, 32'hBEEF_0000, 4'b1100);
    do_write(12'h003, 3'd0, 32'h5A00_0000, 4'b1000);

    // Read with one wait state
    do_read(12'hFE0, 32'h0000_0017);

    // Illegal halfword write: two-cycle ERROR, no strobe
    addr_phase(12'h001, 3'd1, 1'b1);
    go_idle();
    check("err1_hresp",     32'(hresps),     32'h1);
    check("err1_hreadyout", 32'(hreadyouts), 32'h0);
    check("err1_write_en",  32'(write_en),   32'h0);
    @(posedge hclk); #1;
    check("err2_hresp",     32'(hresps),     32'h1);
    check("err2_hreadyout", 32'(hreadyouts), 32'h1);
    check("err2_write_en",  32'(write_en),   32'h0);
    @(posedge hclk); #1;
    check("post_err_hresp", 32'(hresps),     32'h0);

    // Misaligned word read and oversized transfer are also illegal
    addr_phase(12'h006, 3'd2, 1'b0);
    go_idle();
    check("err_word_hresp",   32'(hresps),  32'h1);
    check("err_word_read_en", 32'(read_en), 32'h0);
    @(posedge hclk); #1;
    addr_phase(12'h000, 3'd3, 1'b1);
    go_idle();
    check("err_size_hresp",   32'(hresps), 32'h1);
    @(posedge hclk); #1;
    @(posedge hclk); #1;

    // Deselected and IDLE/BUSY transfers: OKAY, no strobes
    hsels = 1'b0; haddrs = 12'h010; htranss = 2'b10; hwrites = 1'b1; hsizes = 3'd2;
    @(posedge hclk); #1;
    check("desel_write_en",  32'(write_en),   32'h0);
    check("desel_hreadyout", 32'(hreadyouts), 32'h1);
    hsels = 1'b1; htranss = 2'b01; hwrites = 1'b0;
    @(posedge hclk); #1;
    check("busy_read_en",    32'(read_en),    32'h0);
    check("busy_hresp",      32'(hresps),     32'h0);
    go_idle();

    // Back-to-back write then read of the same word
    wr_q.push_back('{a: 12'h000, s: 4'b1111, d: 32'h1122_3344});
    rd_q.push_back(32'h1122_3344);
    addr_phase(12'h000, 3'd2, 1'b1);
    hwdatas = 32'h1122_3344;
    check("b2b_write_en", 32'(write_en), 32'h1);
    addr_phase(12'h000, 3'd2, 1'b0);
    go_idle();
    check("b2b_rdw_read_en",   32'(read_en),    32'h1);
    check("b2b_rdw_hreadyout", 32'(hreadyouts), 32'h0);
    @(posedge hclk); #1;
    check("b2b_rdd_hreadyout", 32'(hreadyouts), 32'h1);
    check("b2b_rdd_hrdata",    hrdatas,         rd_q.pop_front());

    // Reset pulsed during RD_WAIT aborts the read
    addr_phase(12'hFE0, 3'd2, 1'b0);
    go_idle();
    check("rst_rdw_read_en", 32'(read_en), 32'h1);
    #2 hresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    check("postrst_read_en",   32'(read_en),    32'h0);
    check("postrst_hreadyout", 32'(hreadyouts), 32'h1);
    check("postrst_hrdata",    hrdatas,         32'h0);
    do_read(12'hFE0, 32'h0000_0017);

    repeat (2) @(posedge hclk);
    #1;
    check("wr_queue_drained", 32'(wr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_int_ctrl_ahb_if
`default_nettype wire
